stack_pointer_unit: RTL

- Owns the MCU stack pointer.
- Supplies SP and SP-1 to the 4-input 8-bit scratch-RAM address select mux as its C and D inputs.
- Applies load, push and pop strobes from the control unit.
- Tracks stack depth and raises sticky overflow/underflow flags so that illegal pushes and pops are suppressed instead of silently corrupting the scratch RAM.

---
 rtl/stack_pkg.sv | 16 +
 rtl/sp_op_decode.sv | 25 ++
 rtl/stack_pointer_unit.sv | 115 +++++++++++
 3 files changed

// File: rtl/stack_pkg.sv
// Shared stack-pointer definitions, also used by the control unit and the
// scratch-RAM address mux.
package stack_pkg;

    localparam int SP_WIDTH = 8;
    localparam logic [SP_WIDTH-1:0] SP_RESET_VAL = 8'h00;

    typedef enum logic [2:0] {
        SP_HOLD,
        SP_LOAD,
        SP_PUSH,
        SP_POP,
        SP_ILLEGAL
    } sp_op_t;

endpackage

// File: rtl/sp_op_decode.sv
// Maps the control-unit strobes onto a single stack operation.
// Load dominates; a simultaneous push and pop is illegal.
module sp_op_decode
    import stack_pkg::*;
(
    input  logic   i_ld,
    input  logic   i_incr,
    input  logic   i_decr,
    output sp_op_t o_op
);

    always_comb begin
        o_op = SP_HOLD;
        if (i_ld) begin
            o_op = SP_LOAD;
        end else if (i_incr && i_decr) begin
            o_op = SP_ILLEGAL;
        end else if (i_decr) begin
            o_op = SP_PUSH;
        end else if (i_incr) begin
            o_op = SP_POP;
        end
    end

endmodule

// File: rtl/stack_pointer_unit.sv
// MCU stack pointer with depth tracking; pushes past MAX_DEPTH and pops
// below zero are suppressed and reported through sticky flags and ERR.
module stack_pointer_unit
    import stack_pkg::*;
#(
    parameter int                WIDTH     = SP_WIDTH,
    parameter logic [WIDTH-1:0]  SP_RESET  = SP_RESET_VAL,
    parameter int                MAX_DEPTH = 256
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             SP_LD,
    input  logic             SP_INCR,
    input  logic             SP_DECR,
    input  logic [WIDTH-1:0] DATA_IN,
    input  logic             CLR_FLAGS,
    output logic [WIDTH-1:0] SP_OUT,
    output logic [WIDTH-1:0] SP_M1,
    output logic [WIDTH:0]   DEPTH,
    output logic             EMPTY,
    output logic             FULL,
    output logic             OVF,
    output logic             UNF,
    output logic             ERR
);

    localparam logic [WIDTH:0]   LP_MAX_DEPTH = (WIDTH+1)'(MAX_DEPTH);
    localparam logic [WIDTH:0]   LP_DEPTH_ONE = (WIDTH+1)'(1);
    localparam logic [WIDTH-1:0] LP_SP_ONE    = WIDTH'(1);

    logic [WIDTH-1:0] r_sp;
    logic [WIDTH:0]   r_depth;
    logic             r_ovf;
    logic             r_unf;
    logic             r_err;

    logic [WIDTH-1:0] w_sp_next;
    logic [WIDTH:0]   w_depth_next;
    logic             w_ovf_next;
    logic             w_unf_next;
    logic             w_err_next;
    logic             w_empty;
    logic             w_full;
    logic             w_set_ovf;
    logic             w_set_unf;
    sp_op_t           w_op;

    sp_op_decode u_decode (
        .i_ld   (SP_LD),
        .i_incr (SP_INCR),
        .i_decr (SP_DECR),
        .o_op   (w_op)
    );

    assign w_empty = (r_depth == '0);
    assign w_full  = (r_depth == LP_MAX_DEPTH);

    assign w_set_ovf = (w_op == SP_PUSH) && w_full;
    assign w_set_unf = (w_op == SP_POP)  && w_empty;

    always_comb begin
        w_sp_next    = r_sp;
        w_depth_next = r_depth;
        case (w_op)
            SP_LOAD: begin
                w_sp_next    = DATA_IN;
                w_depth_next = '0;
            end
            SP_PUSH: begin
                if (!w_full) begin
                    w_sp_next    = r_sp - LP_SP_ONE;
                    w_depth_next = r_depth + LP_DEPTH_ONE;
                end
            end
            SP_POP: begin
                if (!w_empty) begin
                    w_sp_next    = r_sp + LP_SP_ONE;
                    w_depth_next = r_depth - LP_DEPTH_ONE;
                end
            end
            default: ;
        endcase
    end

    // A new violation overrides a concurrent clear.
    assign w_ovf_next = w_set_ovf || (r_ovf && !CLR_FLAGS);
    assign w_unf_next = w_set_unf || (r_unf && !CLR_FLAGS);
    assign w_err_next = w_set_ovf || w_set_unf || (w_op == SP_ILLEGAL);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sp    <= SP_RESET;
            r_depth <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_sp    <= w_sp_next;
            r_depth <= w_depth_next;
            r_ovf   <= w_ovf_next;
            r_unf   <= w_unf_next;
            r_err   <= w_err_next;
        end
    end

    assign SP_OUT = r_sp;
    assign SP_M1  = r_sp - LP_SP_ONE;
    assign DEPTH  = r_depth;
    assign EMPTY  = w_empty;
    assign FULL   = w_full;
    assign OVF    = r_ovf;
    assign UNF    = r_unf;
    assign ERR    = r_err;

endmodule
